// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter with registered one-hot grant, binary grant
// index, stall freeze and per-burst beat credit.
module wrr_arbiter #(
   parameter int unsigned CLIENTS  = 32,
   parameter int unsigned WEIGHT_W = 4,
   parameter int unsigned IDX_W    = $clog2(CLIENTS)
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic [CLIENTS-1:0]           request,
   input  logic [CLIENTS*WEIGHT_W-1:0]  weight,
   input  logic                         stall,
   output logic [CLIENTS-1:0]           grant,
   output logic                         grant_valid,
   output logic [IDX_W-1:0]             grant_id
);

   localparam int unsigned CNT_W = WEIGHT_W + 1;

   logic [CLIENTS-1:0]  r_grant;
   logic                r_valid;
   logic [IDX_W-1:0]    r_grant_id;
   logic [IDX_W-1:0]    r_ptr;
   logic [WEIGHT_W-1:0] r_cnt;
   logic [WEIGHT_W-1:0] r_blen;

   logic [WEIGHT_W-1:0] w_weights [CLIENTS];
   logic                w_hold;
   logic [IDX_W-1:0]    w_base;
   logic [IDX_W-1:0]    w_cand;
   logic                w_found;
   logic [IDX_W-1:0]    w_win;
   logic [WEIGHT_W-1:0] w_wsel;
   logic [WEIGHT_W-1:0] w_new_blen;

   // Unpack per-client weight fields.
   for (genvar gi = 0; gi < CLIENTS; gi++) begin : g_weight
      assign w_weights[gi] = weight[gi*WEIGHT_W +: WEIGHT_W];
   end

   // Keep the current burst while its request stays up and credit remains;
   // the wider compare keeps cnt+1 from wrapping at the maximum weight.
   always_comb begin
      w_hold = 1'b0;
      if (r_valid && request[r_grant_id] &&
          ((CNT_W'(r_cnt) + CNT_W'(1)) < CNT_W'(r_blen))) begin
         w_hold = 1'b1;
      end
   end

   // Round-robin search from the slot after the last winner; the last
   // winner itself is visited last so a sole requester is re-granted.
   always_comb begin
      w_base  = r_valid ? r_grant_id : r_ptr;
      w_found = 1'b0;
      w_win   = '0;
      w_cand  = '0;
      for (int k = 1; k <= int'(CLIENTS); k++) begin
         w_cand = IDX_W'((int'(w_base) + k) % int'(CLIENTS));
         if (!w_found && request[w_cand]) begin
            w_found = 1'b1;
            w_win   = w_cand;
         end
      end
   end

   // Burst length of the winner, with weight 0 behaving as a single beat.
   always_comb begin
      w_wsel     = w_weights[w_win];
      w_new_blen = (w_wsel == '0) ? WEIGHT_W'(1) : w_wsel;
   end

   // Arbiter state: reset beats stall, stall freezes everything.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_grant    <= '0;
         r_valid    <= 1'b0;
         r_grant_id <= '0;
         r_ptr      <= IDX_W'(CLIENTS - 1);
         r_cnt      <= '0;
         r_blen     <= WEIGHT_W'(1);
      end else if (!stall) begin
         if (w_hold) begin
            r_cnt <= r_cnt + WEIGHT_W'(1);
         end else if (w_found) begin
            r_grant    <= CLIENTS'(1) << w_win;
            r_valid    <= 1'b1;
            r_grant_id <= w_win;
            r_ptr      <= w_win;
            r_cnt      <= '0;
            r_blen     <= w_new_blen;
         end else begin
            r_grant    <= '0;
            r_valid    <= 1'b0;
            r_grant_id <= '0;
         end
      end
   end

   assign grant       = r_grant;
   assign grant_valid = r_valid;
   assign grant_id    = r_grant_id;

endmodule

// File: tb/tb_wrr_arbiter.sv
// Bench for wrr_arbiter: directed vector table on a 4-client instance, then
// randomized traffic on a 4-client and a 5-client instance against a
// credit-based reference model.
module tb_wrr_arbiter;

   logic        clock;
   logic        reset;
   logic        stall;

   logic [3:0]  req4;
   logic [15:0] wt4;
   logic [3:0]  g4;
   logic        v4;
   logic [1:0]  id4;

   logic [4:0]  req5;
   logic [9:0]  wt5;
   logic [4:0]  g5;
   logic        v5;
   logic [2:0]  id5;

   int n_total;
   int n_bad;

   wrr_arbiter #(.CLIENTS(4), .WEIGHT_W(4)) u_dut4 (
      .clock(clock), .reset(reset), .request(req4), .weight(wt4),
      .stall(stall), .grant(g4), .grant_valid(v4), .grant_id(id4)
   );

   wrr_arbiter #(.CLIENTS(5), .WEIGHT_W(2)) u_dut5 (
      .clock(clock), .reset(reset), .request(req5), .weight(wt5),
      .stall(stall), .grant(g5), .grant_valid(v5), .grant_id(id5)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic        rst;
      logic        stl;
      logic [3:0]  req;
      logic [15:0] wt;
      logic [3:0]  g;
   } vec_t;

   vec_t tbl[$];

   // Reference model state: holder (-1 = none), beats of credit left after
   // the current one, and the last winner used as round-robin origin.
   int m_cur    [2];
   int m_credit [2];
   int m_last   [2];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic add_v(input logic rst, input logic stl, input logic [3:0] req,
                        input logic [15:0] wt, input logic [3:0] g);
      vec_t v;
      v.rst = rst; v.stl = stl; v.req = req; v.wt = wt; v.g = g;
      tbl.push_back(v);
   endtask

   function automatic int onehot_idx(input logic [7:0] g);
      int r;
      r = 0;
      for (int i = 0; i < 8; i++) if (g[i]) r = i;
      return r;
   endfunction

   task automatic model_step(input int m, input int n, input int ww,
                             input logic [7:0] rq, input logic [31:0] wts,
                             input logic rst, input logic stl);
      int start;
      int win;
      int c;
      int wv;
      if (rst) begin
         m_cur[m]    = -1;
         m_credit[m] = 0;
         m_last[m]   = n - 1;
      end else if (!stl) begin
         if (m_cur[m] >= 0 && rq[m_cur[m]] && m_credit[m] > 0) begin
            m_credit[m] = m_credit[m] - 1;
         end else begin
            start = (m_cur[m] >= 0) ? m_cur[m] : m_last[m];
            win   = -1;
            for (int k = 1; k <= n; k++) begin
               c = (start + k) % n;
               if (win < 0 && rq[c]) win = c;
            end
            if (win >= 0) begin
               wv          = int'((wts >> (win * ww)) & ((32'd1 << ww) - 32'd1));
               m_cur[m]    = win;
               m_last[m]   = win;
               m_credit[m] = ((wv == 0) ? 1 : wv) - 1;
            end else begin
               m_cur[m] = -1;
            end
         end
      end
   endtask

   task automatic model_check(input int m, input logic [7:0] g, input logic v,
                              input logic [7:0] id);
      logic [7:0] eg;
      eg = (m_cur[m] >= 0) ? (8'd1 << m_cur[m]) : 8'd0;
      chk($sformatf("rnd%0d_grant", m), 64'(g), 64'(eg));
      chk($sformatf("rnd%0d_valid", m), 64'(v), 64'(m_cur[m] >= 0));
      chk($sformatf("rnd%0d_id", m), 64'(id), 64'((m_cur[m] >= 0) ? m_cur[m] : 0));
   endtask

   initial begin
      logic [3:0] eg;
      n_total = 0;
      n_bad   = 0;
      reset = 1'b1; stall = 1'b0;
      req4 = '0; wt4 = '0; req5 = '0; wt5 = '0;

      // All weights 1, everyone requesting: plain rotation from client 0.
      add_v(1, 0, 4'hF, 16'h1111, 4'h0);
      add_v(0, 0, 4'hF, 16'h1111, 4'h1);
      add_v(0, 0, 4'hF, 16'h1111, 4'h2);
      add_v(0, 0, 4'hF, 16'h1111, 4'h4);
      add_v(0, 0, 4'hF, 16'h1111, 4'h8);
      add_v(0, 0, 4'hF, 16'h1111, 4'h1);
      // Weights 3 and 2 on clients 0 and 1.
      add_v(1, 0, 4'h3, 16'h0023, 4'h0);
      for (int r = 0; r < 2; r++) begin
         add_v(0, 0, 4'h3, 16'h0023, 4'h1);
         add_v(0, 0, 4'h3, 16'h0023, 4'h1);
         add_v(0, 0, 4'h3, 16'h0023, 4'h1);
         add_v(0, 0, 4'h3, 16'h0023, 4'h2);
         add_v(0, 0, 4'h3, 16'h0023, 4'h2);
      end
      // Sole requester with weight 0 is re-granted every cycle.
      add_v(1, 0, 4'h4, 16'h0000, 4'h0);
      for (int r = 0; r < 4; r++) add_v(0, 0, 4'h4, 16'h0000, 4'h4);
      // Request drop mid-burst forfeits remaining credit.
      add_v(1, 0, 4'h9, 16'h1004, 4'h0);
      add_v(0, 0, 4'h9, 16'h1004, 4'h1);
      add_v(0, 0, 4'h9, 16'h1004, 4'h1);
      add_v(0, 0, 4'h8, 16'h1004, 4'h8);
      add_v(0, 0, 4'h8, 16'h1004, 4'h8);
      add_v(0, 0, 4'h9, 16'h1004, 4'h1);
      // Stall freezes the grant even while its request drops.
      add_v(1, 0, 4'h2, 16'h0040, 4'h0);
      add_v(0, 0, 4'h2, 16'h0040, 4'h2);
      add_v(0, 0, 4'h2, 16'h0040, 4'h2);
      add_v(0, 1, 4'h2, 16'h0040, 4'h2);
      for (int r = 0; r < 4; r++) add_v(0, 1, 4'h0, 16'h0040, 4'h2);
      add_v(0, 0, 4'h4, 16'h0040, 4'h4);
      add_v(0, 0, 4'h4, 16'h0040, 4'h4);
      // Reset wins over stall in the middle of a burst.
      add_v(1, 0, 4'h4, 16'h4444, 4'h0);
      add_v(0, 0, 4'h4, 16'h4444, 4'h4);
      add_v(0, 0, 4'h4, 16'h4444, 4'h4);
      add_v(0, 0, 4'h4, 16'h4444, 4'h4);
      add_v(1, 1, 4'hF, 16'h4444, 4'h0);
      add_v(0, 0, 4'hF, 16'h4444, 4'h1);
      add_v(0, 0, 4'hF, 16'h4444, 4'h1);
      // Weight change mid-burst only applies at the next burst.
      add_v(1, 0, 4'h3, 16'h0013, 4'h0);
      add_v(0, 0, 4'h3, 16'h0013, 4'h1);
      add_v(0, 0, 4'h3, 16'h0011, 4'h1);
      add_v(0, 0, 4'h3, 16'h0011, 4'h1);
      add_v(0, 0, 4'h3, 16'h0011, 4'h2);
      add_v(0, 0, 4'h3, 16'h0011, 4'h1);
      add_v(0, 0, 4'h3, 16'h0011, 4'h2);

      foreach (tbl[i]) begin
         @(negedge clock);
         reset = tbl[i].rst; stall = tbl[i].stl;
         req4  = tbl[i].req; wt4   = tbl[i].wt;
         @(posedge clock);
         #1;
         eg = tbl[i].g;
         chk($sformatf("vec%0d_grant", i), 64'(g4), 64'(eg));
         chk($sformatf("vec%0d_valid", i), 64'(v4), 64'(|eg));
         chk($sformatf("vec%0d_id", i), 64'(id4), 64'(onehot_idx(8'(eg))));
      end

      // Randomized traffic on both instances; requests stay up until granted.
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(negedge clock);
         reset = (cyc == 0) || ($urandom_range(0, 199) == 0);
         stall = ($urandom_range(0, 4) == 0);
         if (m_cur[0] >= 0 && $urandom_range(0, 1) == 0) req4[m_cur[0]] = 1'b0;
         if (m_cur[1] >= 0 && $urandom_range(0, 1) == 0) req5[m_cur[1]] = 1'b0;
         req4 = req4 | 4'($urandom & $urandom & $urandom);
         req5 = req5 | 5'($urandom & $urandom & $urandom);
         wt4  = 16'($urandom);
         wt5  = 10'($urandom);
         @(posedge clock);
         model_step(0, 4, 4, 8'(req4), 32'(wt4), reset, stall);
         model_step(1, 5, 2, 8'(req5), 32'(wt5), reset, stall);
         #1;
         model_check(0, 8'(g4), v4, 8'(id4));
         model_check(1, 8'(g5), v5, 8'(id5));
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
